// File: rtl/bs_scheduler.sv
// Round-robin scheduler sharing one combinational barrel_shifter among NUM_REQ requesters.
// Registers the granted operands onto the shifter, captures the result, and returns it with the requester ID.
module bs_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_in,
  input  logic [NUM_REQ*SHAMT_W-1:0] req_shift_amt,
  input  logic [NUM_REQ-1:0]         req_shift_rotate,
  input  logic [NUM_REQ-1:0]         req_left_right,
  output logic [DATA_W-1:0]          bs_data_in,
  output logic [SHAMT_W-1:0]         bs_shift_amt,
  output logic                       bs_shift_rotate,
  output logic                       bs_left_right,
  input  logic [DATA_W-1:0]          bs_data_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [ID_W-1:0]            rsp_id,
  output logic [15:0]                ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [DATA_W-1:0]  bs_data_q, bs_data_d;
  logic [SHAMT_W-1:0] bs_amt_q, bs_amt_d;
  logic               bs_rot_q, bs_rot_d;
  logic               bs_lr_q, bs_lr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [15:0]        ops_done_q, ops_done_d;

  logic [DATA_W-1:0]  data_arr [NUM_REQ];
  logic [SHAMT_W-1:0] amt_arr  [NUM_REQ];

  logic               any_valid;
  logic [ID_W-1:0]    gnt_idx;
  logic               can_accept;
  logic               accept;
  logic               rsp_hs;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data_in[gi*DATA_W +: DATA_W];
    assign amt_arr[gi]  = req_shift_amt[gi*SHAMT_W +: SHAMT_W];
  end

  // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    logic [NUM_REQ-1:0] rv_shift;
    int unsigned        idx;
    any_valid = 1'b0;
    gnt_idx   = '0;
    rv_shift  = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx      = (int'(ptr_q) + k) % NUM_REQ;
      rv_shift = req_valid >> idx;
      if (!any_valid && rv_shift[0]) begin
        any_valid = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = accept ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    can_accept = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
    accept     = can_accept && any_valid;
    rsp_hs     = (state_q == RESP) && rsp_ready;
    req_ready  = accept ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

  always_comb begin
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    bs_data_d   = bs_data_q;
    bs_amt_d    = bs_amt_q;
    bs_rot_d    = bs_rot_q;
    bs_lr_d     = bs_lr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    ops_done_d  = ops_done_q;
    if (accept) begin
      bs_data_d = data_arr[gnt_idx];
      bs_amt_d  = amt_arr[gnt_idx];
      bs_rot_d  = req_shift_rotate[gnt_idx];
      bs_lr_d   = req_left_right[gnt_idx];
      grant_d   = gnt_idx;
      ptr_d     = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
    if (state_q == EXEC) begin
      rsp_data_d  = bs_data_out;
      rsp_id_d    = grant_q;
      rsp_valid_d = 1'b1;
    end
    if (rsp_hs) begin
      rsp_valid_d = 1'b0;
      ops_done_d  = (ops_done_q != 16'hFFFF) ? ops_done_q + 16'd1 : ops_done_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      grant_q     <= '0;
      bs_data_q   <= '0;
      bs_amt_q    <= '0;
      bs_rot_q    <= 1'b0;
      bs_lr_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      ops_done_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      bs_data_q   <= bs_data_d;
      bs_amt_q    <= bs_amt_d;
      bs_rot_q    <= bs_rot_d;
      bs_lr_q     <= bs_lr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign bs_data_in      = bs_data_q;
  assign bs_shift_amt    = bs_amt_q;
  assign bs_shift_rotate = bs_rot_q;
  assign bs_left_right   = bs_lr_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_id          = rsp_id_q;
  assign ops_done        = ops_done_q;

endmodule

// File: doc/bs_scheduler.md
Name: bs_scheduler

Overview:
Round-robin scheduler that shares one combinational barrel_shifter instance among NUM_REQ requesters. It accepts shift/rotate requests over per-requester valid/ready handshakes and registers the chosen operands onto the shifter inputs. It then captures the shifter result and returns it with the requester ID over a valid/ready response channel. It sits between requester blocks and the single barrel_shifter in the datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, shifter data width
SHAMT_W, 5, shift-amount width (= $clog2(DATA_W))
ID_W, 2, requester-ID width (= $clog2(NUM_REQ))

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
req_data_in  input  NUM_REQ*DATA_W  packed operands, requester i at [i*DATA_W +: DATA_W]
req_shift_amt  input  NUM_REQ*SHAMT_W  packed shift amounts
req_shift_rotate  input  NUM_REQ  0 = shift, 1 = rotate
req_left_right  input  NUM_REQ  0 = left, 1 = right
bs_data_in  output  DATA_W  registered operand to barrel_shifter
bs_shift_amt  output  SHAMT_W  registered amount to barrel_shifter
bs_shift_rotate  output  1  registered mode to barrel_shifter
bs_left_right  output  1  registered direction to barrel_shifter
bs_data_out  input  DATA_W  combinational result from barrel_shifter
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_data  output  DATA_W  captured shifter result
rsp_id  output  ID_W  index of the requester served
ops_done  output  16  completed-response counter, saturates at 0xFFFF

Behaviour:
- Reset (asynchronous, active-high) puts the block in state IDLE.
  - All bs_* outputs, rsp_data, rsp_id and ops_done go to 0; rsp_valid goes to 0.
  - The round-robin pointer goes to 0.
  - Any in-flight request or response is discarded.
- req_ready is combinational from req_valid, state and pointer.
  - At most one bit is high.
  - It is high only when that requester's valid is high and the block can accept.
- Accept condition, can_accept: (state == IDLE) or (state == RESP and rsp_ready).
- Grant selection: the first i with req_valid[i] = 1, searching from pointer upward with wrap-around modulo NUM_REQ.
- States:
  - IDLE:
    - If can_accept and any req_valid: assert req_ready[g].
    - At the clock edge: latch requester g's operands into bs_*, latch g into a grant register, pointer <= (g+1) mod NUM_REQ, go to EXEC.
    - Otherwise stay in IDLE.
  - EXEC (one cycle):
    - At the edge: rsp_data <= bs_data_out, rsp_id <= grant register, rsp_valid <= 1, go to RESP.
  - RESP:
    - rsp_valid, rsp_data and rsp_id are held stable until rsp_ready = 1.
    - On handshake: ops_done increments (saturating at 0xFFFF).
    - If a request is granted in the same cycle: latch the new operands, go to EXEC, rsp_valid <= 0.
    - Otherwise: go to IDLE, rsp_valid <= 0.
- Latency and throughput:
  - Request accept edge to rsp_valid high: 2 cycles.
  - Back-to-back throughput: one response per 2 cycles when rsp_ready is held high.
- bs_* outputs hold their last value in IDLE and RESP; they change only on an accept edge.
- No requests are accepted in EXEC, or in RESP while rsp_ready = 0 (backpressure).
- The controller never modifies operands; the shift semantics belong to barrel_shifter.
- A requester may drop req_valid without being served; the block takes no action.
- A requester must hold req_valid and its operands stable until req_ready.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,...
- Reset asserted in EXEC or RESP aborts the operation; rsp_valid goes to 0 immediately (asynchronous).

Test Plan:
1. Reset, then req 0 only: data_in 0x8000_0001, rotate, left, amt 1 -> req_ready[0] high one cycle; 2 cycles later rsp_valid=1, rsp_data=0x0000_0003, rsp_id=0; ops_done=1 after handshake.
2. All 4 requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0; one response every 2 cycles; req_ready always one-hot.
3. Req 2: 0xF000_0000, shift, right, amt 4; rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_data=0x0F00_0000 and rsp_id=2 stable for all 5 cycles; req 1 raised meanwhile gets no req_ready until the handshake cycle.
4. Pointer wrap: pointer=3 with req 3 and req 0 valid -> req 3 granted first, then req 0; bs_* change only on accept edges.
5. Assert reset asynchronously mid-EXEC and mid-RESP -> rsp_valid, bs_*, ops_done and pointer go to 0 without waiting for a clock edge; the next request is served from requester 0 priority.
6. Drive 65536+ handshakes (or force the counter near max) -> ops_done saturates at 0xFFFF and does not wrap.
